// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store front-end: access sizes,
// FSM states and the default data-memory word-address width.
package mips_mem_pkg;

    localparam int unsigned MEM_WIDTH_DEFAULT = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRmwWrite,
        StResp
    } state_e;

endpackage

// File: rtl/lane_align.sv
// Big-endian lane steering: extracts/extends a load value from a memory word and
// merges sub-word store data into a word for read-modify-write.
module lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0]  shamt;
    logic [15:0] lane;

    always_comb begin
        shamt    = '0;
        lane     = '0;
        load_o   = word_i;
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                // Offset 0 is the most significant byte, so shift by (3 - offset) bytes.
                shamt    = {~offset_i, 3'b000};
                lane     = 16'(word_i >> shamt);
                load_o   = unsigned_i ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
                merged_o = (word_i & ~(32'h0000_00ff << shamt))
                         | ({24'b0, wdata_i[7:0]} << shamt);
            end
            SZ_HALF: begin
                shamt    = {~offset_i[1], 4'b0000};
                lane     = 16'(word_i >> shamt);
                load_o   = unsigned_i ? {16'b0, lane} : {{16{lane[15]}}, lane};
                merged_o = (word_i & ~(32'h0000_ffff << shamt))
                         | ({16'b0, wdata_i} << shamt);
            end
            default: begin
                load_o   = word_i;
                merged_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end: turns byte/half/word requests into word accesses
// on a 16x32 memory, using read-modify-write for sub-word stores.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WIDTH  = MEM_WIDTH_DEFAULT
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wea,
    output logic [MEM_WIDTH-1:0]  mem_addra,
    output logic [DATA_WIDTH-1:0] mem_dina,
    input  logic [DATA_WIDTH-1:0] mem_douta
);

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [MEM_WIDTH-1:0]  waddr_q, waddr_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_err;
    logic [DATA_WIDTH-1:0] lane_word;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merged_val;

    always_comb begin
        req_err = (req_size == 2'b11)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                || ((req_addr >> (MEM_WIDTH + 2)) != 32'd0);
    end

    // The merge register feeds the aligner only while writing back a sub-word store.
    assign lane_word = (state_q == StRmwWrite) ? merge_q : mem_douta;

    lane_align u_lane_align (
        .word_i     (lane_word),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q[15:0]),
        .load_o     (load_val),
        .merged_o   (merged_val)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        waddr_d = waddr_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    waddr_d = req_addr[MEM_WIDTH+1:2];
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = req_err ? StResp : StAccess;
                end
            end
            StAccess: begin
                if (!write_q) begin
                    rdata_d = load_val;
                    state_d = StResp;
                end else if (size_q == SZ_WORD) begin
                    state_d = StResp;
                end else begin
                    merge_d = mem_douta;
                    state_d = StRmwWrite;
                end
            end
            StRmwWrite: state_d = StResp;
            StResp:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid && err_q;
        mem_addra  = waddr_q;
        mem_wea    = !reset && ((state_q == StAccess && write_q && size_q == SZ_WORD)
                                || state_q == StRmwWrite);
        mem_dina   = '0;
        if (state_q == StAccess && write_q && size_q == SZ_WORD) begin
            mem_dina = wdata_q;
        end else if (state_q == StRmwWrite) begin
            mem_dina = merged_val;
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            waddr_q <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            waddr_q <= waddr_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random traffic scored against a
// byte-addressed big-endian memory model.
module tb_mem_access_unit;

    logic        clka = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wea;
    logic [3:0]  mem_addra;
    logic [31:0] mem_dina;
    logic [31:0] mem_douta;

    logic [31:0] dut_mem  [16];
    logic [31:0] init_mem [16];
    logic [31:0] ref_mem  [16];
    logic        load_en;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit dut (
        .clka         (clka),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_wea      (mem_wea),
        .mem_addra    (mem_addra),
        .mem_dina     (mem_dina),
        .mem_douta    (mem_douta)
    );

    always #5 clka = ~clka;

    assign mem_douta = dut_mem[mem_addra];

    always @(posedge clka) begin
        if (load_en) begin
            for (int i = 0; i < 16; i++) dut_mem[i] <= init_mem[i];
        end else if (mem_wea) begin
            dut_mem[mem_addra] <= mem_dina;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int a);
        logic [31:0] wd;
        wd = ref_mem[a / 4];
        return wd[8 * (3 - (a % 4)) +: 8];
    endfunction

    function automatic void ref_set_byte(input int a, input logic [7:0] b);
        logic [31:0] wd;
        wd = ref_mem[a / 4];
        wd[8 * (3 - (a % 4)) +: 8] = b;
        ref_mem[a / 4] = wd;
    endfunction

    task automatic run_req(input string tag, input logic w, input logic [1:0] sz,
                           input logic u, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] got_rd, output logic got_err,
                           output int got_lat);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [63:0] v;
        int          nb, exp_lat, exp_mask, mask, nresp;
        logic [3:0]  waddr;

        // Reference: byte-addressed view of memory, big-endian.
        exp_err = (sz == 2'b11) || (a > 32'd63) || (a % (32'd1 << sz) != 0);
        exp_rd  = '0;
        nb      = 1 << sz;
        if (exp_err) begin
            exp_lat  = 1;
            exp_mask = 0;
        end else if (!w) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 64'(ref_byte(int'(a) + i));
            if (!u && v[8 * nb - 1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
            exp_rd   = v[31:0];
            exp_lat  = 2;
            exp_mask = 0;
        end else begin
            for (int i = 0; i < nb; i++) ref_set_byte(int'(a) + i, d[8 * (nb - 1 - i) +: 8]);
            exp_lat  = (sz == 2'b10) ? 2 : 3;
            exp_mask = (sz == 2'b10) ? 2 : 4;
        end

        @(negedge clka);
        check_eq({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        @(posedge clka);
        #1 req_valid = 1'b0;
        got_lat = -1;
        got_rd  = '0;
        got_err = 1'b0;
        nresp   = 0;
        mask    = 0;
        waddr   = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clka);
            if (k == 1) check_eq({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
            if (mem_wea) begin
                mask  = mask | (1 << k);
                waddr = mem_addra;
            end
            if (resp_valid) begin
                nresp++;
                if (got_lat < 0) begin
                    got_lat = k;
                    got_rd  = resp_rdata;
                    got_err = resp_err;
                end
            end
        end
        check_eq({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
        check_eq({tag, "_nresp"}, 32'(nresp), 32'd1);
        check_eq({tag, "_rdata"}, got_rd, exp_rd);
        check_eq({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check_eq({tag, "_wea_cycles"}, 32'(mask), 32'(exp_mask));
        if (exp_mask != 0) begin
            check_eq({tag, "_wea_addr"}, 32'(waddr), 32'(a[5:2]));
            check_eq({tag, "_memword"}, dut_mem[a[5:2]], ref_mem[a[5:2]]);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, acc, nresp;
        logic        w, u;
        logic [1:0]  sz;
        logic [31:0] a, d;

        for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
        init_mem[2] = 32'h1122_3344;
        init_mem[3] = 32'h80FF_1234;
        init_mem[4] = 32'hCAFE_0042;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];

        reset = 1'b1;
        load_en = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", 32'(resp_err), 32'd0);
        check_eq("rst_wea", 32'(mem_wea), 32'd0);
        check_eq("rst_addra", 32'(mem_addra), 32'd0);
        check_eq("rst_dina", mem_dina, 32'd0);
        reset = 1'b0;
        load_en = 1'b0;

        run_req("lb_0c", 1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, rd, er, lat);
        check_eq("lb_0c_const", rd, 32'hFFFF_FF80);
        run_req("lbu_0d", 1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, rd, er, lat);
        check_eq("lbu_0d_const", rd, 32'h0000_00FF);
        run_req("lh_0e", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, rd, er, lat);
        check_eq("lh_0e_const", rd, 32'h0000_1234);
        run_req("sb_09", 1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_00AB, rd, er, lat);
        check_eq("sb_09_word2", dut_mem[2], 32'h11AB_3344);
        run_req("sw_3c", 1'b1, 2'b10, 1'b0, 32'h3C, 32'hDEAD_BEEF, rd, er, lat);
        run_req("lw_3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, rd, er, lat);
        check_eq("lw_3c_const", rd, 32'hDEAD_BEEF);
        run_req("lw_06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, er, lat);
        check_eq("lw_06_err", 32'(er), 32'd1);
        run_req("sh_03", 1'b1, 2'b01, 1'b0, 32'h03, 32'h5555, rd, er, lat);
        check_eq("sh_03_err", 32'(er), 32'd1);
        run_req("lw_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
        check_eq("lw_40_err", 32'(er), 32'd1);

        // Reset landing on the write-back cycle of a sub-word store.
        @(negedge clka);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b01;
        req_unsigned = 1'b0;
        req_addr = 32'h12;
        req_wdata = 32'h0000_BEEF;
        @(posedge clka);
        #1 req_valid = 1'b0;
        @(posedge clka);
        #1 reset = 1'b1;
        @(negedge clka);
        check_eq("abort_wea", 32'(mem_wea), 32'd0);
        @(posedge clka);
        #1 reset = 1'b0;
        nresp = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clka);
            if (resp_valid) nresp++;
        end
        check_eq("abort_nresp", 32'(nresp), 32'd0);
        check_eq("abort_ready", 32'(req_ready), 32'd1);
        check_eq("abort_word4", dut_mem[4], 32'hCAFE_0042);

        // req_valid held high across back-to-back loads.
        @(negedge clka);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'h0C;
        acc = 0;
        nresp = 0;
        for (int i = 0; i < 15; i++) begin
            if (resp_valid) begin
                nresp++;
                check_eq("b2b_rdata", resp_rdata, 32'hFFFF_FF80);
                check_eq("b2b_ready_in_resp", 32'(req_ready), 32'd0);
            end
            if (i < 14 && req_ready) acc++;
            if (i == 14) req_valid = 1'b0;
            @(negedge clka);
        end
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) nresp++;
            @(negedge clka);
        end
        check_eq("b2b_accepts", 32'(acc), 32'd5);
        check_eq("b2b_resp_count", 32'(nresp), 32'(acc));

        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63));
            if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            d  = $urandom;
            run_req($sformatf("rnd%0d", i), w, sz, u, a, d, rd, er, lat);
        end

        for (int i = 0; i < 16; i++) check_eq($sformatf("final_mem%0d", i), dut_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
